latch_q_sampler: RTL and testbench

Clocked consumer for the asynchronous output of the D latch stage. It synchronizes the latch `Q` into the system clock domain and debounces it with a small state machine. From the filtered level it produces one-cycle rise/fall pulses and maintains a saturating transition counter. Downstream logic uses `Q_filt`, the edge pulses and `edge_cnt`, never the raw latch output.

---
 rtl/latch_q_sampler.sv | 131 +++++++++++++
 tb/tb_latch_q_sampler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/latch_q_sampler.sv
// rtl/latch_q_sampler.sv - synchronize, debounce and edge-count the D latch Q output
module latch_q_sampler #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Q_in,
  input  logic             clr_cnt,
  output logic             Q_sync,
  output logic             Q_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam logic [3:0]       STAB_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sync1;
  state_t           state;
  state_t           state_nxt;
  logic [3:0]       stab;
  logic [3:0]       stab_nxt;
  logic             filt_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;

  // Only sync1 may go metastable; nothing else looks at Q_in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      Q_sync <= 1'b0;
    end else begin
      sync1  <= Q_in;
      Q_sync <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE_LOW;
      stab     <= 4'd0;
      Q_filt   <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else begin
      state    <= state_nxt;
      stab     <= stab_nxt;
      Q_filt   <= filt_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      edge_cnt <= cnt_nxt;
      cnt_sat  <= (cnt_nxt == CNT_MAX);
    end
  end

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab;
    filt_nxt  = Q_filt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (Q_sync) begin
          state_nxt = CHK_HIGH;
          stab_nxt  = 4'd1;
        end
      end
      CHK_HIGH: begin
        if (!Q_sync) begin
          state_nxt = IDLE_LOW;
          stab_nxt  = 4'd0;
        end else if (stab == STAB_LAST) begin
          state_nxt = IDLE_HIGH;
          stab_nxt  = 4'd0;
          filt_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          stab_nxt = stab + 4'd1;
        end
      end
      IDLE_HIGH: begin
        if (!Q_sync) begin
          state_nxt = CHK_LOW;
          stab_nxt  = 4'd1;
        end
      end
      CHK_LOW: begin
        if (Q_sync) begin
          state_nxt = IDLE_HIGH;
          stab_nxt  = 4'd0;
        end else if (stab == STAB_LAST) begin
          state_nxt = IDLE_LOW;
          stab_nxt  = 4'd0;
          filt_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          stab_nxt = stab + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        stab_nxt  = 4'd0;
      end
    endcase
  end

  // Clear is applied before the event, so a collision leaves the count at 1.
  always_comb begin
    cnt_base = clr_cnt ? '0 : edge_cnt;
    cnt_nxt  = cnt_base;
    if ((rise_nxt || fall_nxt) && (cnt_base != CNT_MAX)) begin
      cnt_nxt = cnt_base + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_latch_q_sampler.sv
// tb/tb_latch_q_sampler.sv - directed bench for latch_q_sampler (8-bit and 4-bit counters)
module tb_latch_q_sampler;

  logic       clk;
  logic       rst_n;
  logic       Q_in;
  logic       clr_cnt;

  logic       q_sync;
  logic       q_filt;
  logic       rise;
  logic       fall;
  logic [7:0] edge_cnt;
  logic       cnt_sat;

  logic       q_sync4;
  logic       q_filt4;
  logic       rise4;
  logic       fall4;
  logic [3:0] edge_cnt4;
  logic       cnt_sat4;

  int checks;
  int errors;
  int n_rise;
  int n_fall;
  int n_sync;
  int n_both;
  int rise_at;
  int fall_at;
  logic lvl;

  latch_q_sampler #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Q_in     (Q_in),
    .clr_cnt  (clr_cnt),
    .Q_sync   (q_sync),
    .Q_filt   (q_filt),
    .rise     (rise),
    .fall     (fall),
    .edge_cnt (edge_cnt),
    .cnt_sat  (cnt_sat)
  );

  latch_q_sampler #(.STABLE_CYCLES(3), .CNT_W(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .Q_in     (Q_in),
    .clr_cnt  (clr_cnt),
    .Q_sync   (q_sync4),
    .Q_filt   (q_filt4),
    .rise     (rise4),
    .fall     (fall4),
    .edge_cnt (edge_cnt4),
    .cnt_sat  (cnt_sat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive Q_in to v before edge 1, flip it back after edge 'hold', observe edges 1..window.
  task automatic run(input logic v, input int hold, input int window);
    n_rise  = 0;
    n_fall  = 0;
    n_sync  = 0;
    n_both  = 0;
    rise_at = 0;
    fall_at = 0;
    Q_in    = v;
    for (int i = 1; i <= window; i++) begin
      step();
      if (i == hold) Q_in = ~v;
      if (rise) begin
        n_rise++;
        if (rise_at == 0) rise_at = i;
      end
      if (fall) begin
        n_fall++;
        if (fall_at == 0) fall_at = i;
      end
      if (q_sync == v) n_sync++;
      if (rise && fall) n_both++;
    end
  endtask

  task automatic clear();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_cnt8", int'(edge_cnt), 0);
    check("clr_sat8", int'(cnt_sat), 0);
    check("clr_cnt4", int'(edge_cnt4), 0);
    check("clr_sat4", int'(cnt_sat4), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    Q_in    = 1'b1;
    clr_cnt = 1'b0;

    // Reset held 3 cycles with Q_in high and a clear request
    clr_cnt = 1'b1;
    repeat (3) step();
    clr_cnt = 1'b0;
    check("rst_q_sync", int'(q_sync), 0);
    check("rst_q_filt", int'(q_filt), 0);
    check("rst_rise",   int'(rise), 0);
    check("rst_fall",   int'(fall), 0);
    check("rst_cnt",    int'(edge_cnt), 0);
    check("rst_sat",    int'(cnt_sat), 0);
    check("rst_cnt4",   int'(edge_cnt4), 0);

    // Release with Q_in high: rise at k+4
    rst_n = 1'b1;
    run(1'b1, 1000, 6);
    check("rel_rise_at", rise_at, 5);
    check("rel_n_rise",  n_rise, 1);
    check("rel_q_filt",  int'(q_filt), 1);
    check("rel_cnt",     int'(edge_cnt), 1);

    // Drop: fall with the same latency
    run(1'b0, 1000, 6);
    check("drop_fall_at", fall_at, 5);
    check("drop_q_filt",  int'(q_filt), 0);
    check("drop_cnt",     int'(edge_cnt), 2);
    clear();

    // Two-period glitch is rejected
    run(1'b1, 2, 8);
    check("gl_sync_width", n_sync, 2);
    check("gl_n_rise",     n_rise, 0);
    check("gl_q_filt",     int'(q_filt), 0);
    check("gl_cnt",        int'(edge_cnt), 0);

    // Five periods high: one rise, then the fall after the drop
    run(1'b1, 5, 14);
    check("p5_rise_at", rise_at, 5);
    check("p5_n_rise",  n_rise, 1);
    check("p5_fall_at", fall_at, 10);
    check("p5_n_fall",  n_fall, 1);
    check("p5_cnt",     int'(edge_cnt), 2);

    // Full cycle, held 10 periods
    run(1'b1, 10, 20);
    check("fc_rise_at", rise_at, 5);
    check("fc_fall_at", fall_at, 15);
    check("fc_both",    n_both, 0);
    check("fc_cnt",     int'(edge_cnt), 4);
    clear();

    // 20 transitions: 4-bit counter saturates at the 15th
    lvl = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      run(lvl, 1000, 6);
      check("sat_edge_at", lvl ? rise_at : fall_at, 5);
      check("sat_cnt4",    int'(edge_cnt4), (i < 15) ? i : 15);
      check("sat_flag4",   int'(cnt_sat4), (i >= 15) ? 1 : 0);
      check("sat_cnt8",    int'(edge_cnt), i);
      lvl = ~lvl;
    end
    check("sat_flag8", int'(cnt_sat), 0);
    clear();

    // Bring edge_cnt to 7 with Q_filt low
    run(1'b1, 1000, 6);
    clear();
    lvl = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      run(lvl, 1000, 6);
      lvl = ~lvl;
    end
    check("pre_col_cnt",  int'(edge_cnt), 7);
    check("pre_col_filt", int'(q_filt), 0);

    // Clear collides with an accepted rise
    Q_in = 1'b1;
    repeat (4) step();
    check("col_no_early_rise", int'(rise), 0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("col_rise", int'(rise), 1);
    check("col_cnt8", int'(edge_cnt), 1);
    check("col_cnt4", int'(edge_cnt4), 1);
    check("col_sat4", int'(cnt_sat4), 0);
    step();
    check("col_rise_gone", int'(rise), 0);
    check("col_cnt_hold",  int'(edge_cnt), 1);

    // Reset while in CHK_HIGH
    run(1'b0, 1000, 6);
    check("mc_pre_filt", int'(q_filt), 0);
    Q_in = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("mc_rise_a", int'(rise), 0);
    step();
    check("mc_rise_b", int'(rise), 0);
    check("mc_filt",   int'(q_filt), 0);
    check("mc_cnt",    int'(edge_cnt), 0);
    check("mc_sync",   int'(q_sync), 0);
    rst_n = 1'b1;
    run(1'b1, 1000, 6);
    check("mc_rise_at", rise_at, 5);
    check("mc_n_rise",  n_rise, 1);
    check("mc_cnt_end", int'(edge_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
